// File: rtl/whack_round_engine.sv
// Round/score datapath for whack-a-mole: timed rounds, edge-detected hits, score RAM logging.
// Optional WHACK_MISS_PENALTY_EN: a press on a non-mole hole costs one point (floored at 0).
module whack_round_engine #(
    parameter int NUM_HOLES       = 4,
    parameter int SCORE_W         = 8,
    parameter int TICKS_PER_ROUND = 50000000,
    parameter int NUM_ROUNDS      = 16,
    parameter int ADDR_W          = 5
) (
    input  logic                                  clk,
    input  logic                                  Reset,
    input  logic                                  start,
    input  logic [$clog2(NUM_HOLES)-1:0]          mole_sel,
    input  logic [NUM_HOLES-1:0]                  hit_btn,
    output logic [NUM_HOLES-1:0]                  mole_on,
    output logic [SCORE_W-1:0]                    score,
    output logic [$clog2(NUM_ROUNDS+1)-1:0]       round_cnt,
    output logic                                  round_tick,
    output logic                                  game_start,
    output logic                                  game_done,
    output logic                                  wren,
    output logic [ADDR_W-1:0]                     address,
    output logic [SCORE_W-1:0]                    data_out
);

    localparam int HW = $clog2(NUM_HOLES);
    localparam int RW = $clog2(NUM_ROUNDS + 1);
    localparam int TW = $clog2(TICKS_PER_ROUND);

    typedef enum logic [1:0] {IDLE, SHOW, WRITE, DONE} state_t;

    state_t               state;
    logic [NUM_HOLES-1:0] btn_prev;
    logic [TW-1:0]        tick_cnt;
    logic [HW-1:0]        hole;

    logic [NUM_HOLES-1:0] btn_edge;
    logic                 hit;
    logic                 timeout;
    logic                 last_round;
    logic                 launch;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s == {SCORE_W{1'b1}}) ? s : s + 1'b1;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_dec(input logic [SCORE_W-1:0] s);
        return (s == '0) ? s : s - 1'b1;
    endfunction

    function automatic logic [NUM_HOLES-1:0] onehot(input logic [HW-1:0] h);
        logic [NUM_HOLES-1:0] r;
        r    = '0;
        r[h] = 1'b1;
        return r;
    endfunction

    assign btn_edge   = hit_btn & ~btn_prev;
    assign hit        = btn_edge[hole];
    assign timeout    = (tick_cnt == TW'(TICKS_PER_ROUND - 1));
    assign last_round = (round_cnt == RW'(NUM_ROUNDS - 1));
    // In DONE, the cycle with wren still high is the write itself; a new game waits for game_done.
    assign launch     = start && ((state == IDLE) || (state == DONE && !wren));
    assign data_out   = score;

`ifdef WHACK_MISS_PENALTY_EN
    logic miss;
    assign miss = |(btn_edge & ~onehot(hole));
`endif

    always_ff @(posedge clk) begin
        if (Reset) begin
            state      <= IDLE;
            btn_prev   <= '0;
            tick_cnt   <= '0;
            hole       <= '0;
            mole_on    <= '0;
            score      <= '0;
            round_cnt  <= '0;
            round_tick <= 1'b0;
            game_start <= 1'b0;
            game_done  <= 1'b0;
            wren       <= 1'b0;
            address    <= '0;
        end else begin
            btn_prev   <= hit_btn;
            round_tick <= 1'b0;
            wren       <= 1'b0;
            if (launch) begin
                state      <= SHOW;
                score      <= '0;
                round_cnt  <= '0;
                tick_cnt   <= '0;
                hole       <= mole_sel;
                mole_on    <= onehot(mole_sel);
                game_start <= 1'b1;
                game_done  <= 1'b0;
            end else begin
                case (state)
                    SHOW: begin
                        if (hit || timeout) begin
                            if (hit)
                                score <= sat_inc(score);
                            round_tick <= 1'b1;
                            round_cnt  <= round_cnt + 1'b1;
                            if (last_round) begin
                                state   <= WRITE;
                                mole_on <= '0;
                            end else begin
                                tick_cnt <= '0;
                                hole     <= mole_sel;
                                mole_on  <= onehot(mole_sel);
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
`ifdef WHACK_MISS_PENALTY_EN
                            if (miss)
                                score <= sat_dec(score);
`endif
                        end
                    end
                    // Round-end pulse occupies this cycle; the RAM write follows it.
                    WRITE: begin
                        wren       <= 1'b1;
                        game_start <= 1'b0;
                        state      <= DONE;
                    end
                    DONE: begin
                        if (wren) begin
                            address   <= address + 1'b1;
                            game_done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_whack_round_engine.sv
// Directed + randomized bench for whack_round_engine with a game-level reference model.
module tb_whack_round_engine;

    localparam int NH = 4;
    localparam int SW = 2;
    localparam int T  = 8;
    localparam int R  = 5;
    localparam int AW = 2;
    localparam int HW = $clog2(NH);
    localparam int RW = $clog2(R + 1);
    localparam int SMAX = (1 << SW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          Reset;
    logic          start;
    logic [HW-1:0] mole_sel;
    logic [NH-1:0] hit_btn;
    logic [NH-1:0] mole_on;
    logic [SW-1:0] score;
    logic [RW-1:0] round_cnt;
    logic          round_tick;
    logic          game_start;
    logic          game_done;
    logic          wren;
    logic [AW-1:0] address;
    logic [SW-1:0] data_out;

    whack_round_engine #(
        .NUM_HOLES(NH), .SCORE_W(SW), .TICKS_PER_ROUND(T), .NUM_ROUNDS(R), .ADDR_W(AW)
    ) dut (
        .clk(clk), .Reset(Reset), .start(start), .mole_sel(mole_sel), .hit_btn(hit_btn),
        .mole_on(mole_on), .score(score), .round_cnt(round_cnt), .round_tick(round_tick),
        .game_start(game_start), .game_done(game_done), .wren(wren), .address(address),
        .data_out(data_out)
    );

    int compared   = 0;
    int mismatched = 0;

    // Model: md 0=idle 1=playing 2=last round just ended 3=writing 4=game over
    int            md = 0;
    int            m_score = 0, m_rounds = 0, m_ticks = 0, m_hole = 0, m_addr = 0;
    bit            m_tick = 0, m_gstart = 0, m_done = 0, m_wren = 0;
    logic [NH-1:0] m_prev = '0;

    task automatic model_update();
        logic [NH-1:0] edges;
        bit hit, miss;
        if (Reset) begin
            md = 0; m_score = 0; m_rounds = 0; m_ticks = 0; m_hole = 0; m_addr = 0;
            m_tick = 0; m_gstart = 0; m_done = 0; m_wren = 0; m_prev = '0;
            return;
        end
        edges  = hit_btn & ~m_prev;
        m_prev = hit_btn;
        m_tick = 0;
        m_wren = 0;
        if ((md == 0 || md == 4) && start) begin
            md = 1; m_score = 0; m_rounds = 0; m_ticks = 0; m_hole = int'(mole_sel);
            m_gstart = 1; m_done = 0;
        end else if (md == 1) begin
            hit  = edges[m_hole];
            miss = (edges & ~(NH'(1) << m_hole)) != '0;
            if (hit || m_ticks == T - 1) begin
                if (hit && m_score < SMAX) m_score++;
                m_tick = 1;
                m_rounds++;
                if (m_rounds < R) begin
                    m_ticks = 0;
                    m_hole  = int'(mole_sel);
                end else begin
                    md = 2;
                end
            end else begin
                m_ticks++;
`ifdef WHACK_MISS_PENALTY_EN
                if (miss && m_score > 0) m_score--;
`else
                if (miss) m_ticks = m_ticks + 0;
`endif
            end
        end else if (md == 2) begin
            m_wren = 1; m_gstart = 0; md = 3;
        end else if (md == 3) begin
            m_addr = (m_addr + 1) % (1 << AW); m_done = 1; md = 4;
        end
    endtask

    task automatic check(input string tag);
        logic [NH-1:0] e_on;
        e_on = (md == 1) ? (NH'(1) << m_hole) : '0;
        compared++;
        assert ({mole_on, score, round_cnt, round_tick, game_start, game_done, wren, address, data_out} ===
                {e_on, SW'(m_score), RW'(m_rounds), m_tick, m_gstart, m_done, m_wren, AW'(m_addr), SW'(m_score)})
        else begin
            mismatched++;
            $error("FAIL %s t=%0t got on=%b sc=%0d rc=%0d tk=%b gs=%b gd=%b we=%b ad=%0d do=%0d exp on=%b sc=%0d rc=%0d tk=%b gs=%b gd=%b we=%b ad=%0d",
                   tag, $time, mole_on, score, round_cnt, round_tick, game_start, game_done, wren, address, data_out,
                   e_on, m_score, m_rounds, m_tick, m_gstart, m_done, m_wren, m_addr);
        end
    endtask

    task automatic step(input string tag);
        model_update();
        @(posedge clk);
        #1;
        check(tag);
    endtask

    task automatic run_idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            mole_sel = HW'($urandom);
            step(tag);
        end
    endtask

    initial begin
        Reset = 1'b1; start = 1'b0; mole_sel = '0; hit_btn = '0;
        step("reset0");
        step("reset1");
        Reset = 1'b0;
        step("idle");

        // Game with no presses: every round times out.
        mole_sel = 2'd2; start = 1'b1;
        step("start_a");
        start = 1'b0;
        run_idle(R * T + 4, "timeout_game");

        // Hits, held button, misses, simultaneous edges, saturation.
        mole_sel = 2'd2; start = 1'b1;
        step("start_b");
        start = 1'b0; mole_sel = 2'd1;
        hit_btn = 4'b0100; step("hit");
        step("held1"); step("held2");
        hit_btn = 4'b0000; step("release");
        hit_btn = 4'b0001; step("miss1");
        hit_btn = 4'b0000; step("miss_rel");
        hit_btn = 4'b0001; step("miss2");
        hit_btn = 4'b0000; step("miss2_rel");
        hit_btn = (NH'(1) << m_hole) | (NH'(1) << ((m_hole + 1) % NH));
        step("both");
        hit_btn = 4'b0000; step("both_rel");
        for (int i = 0; i < 40 && md == 1; i++) begin
            hit_btn = NH'(1) << m_hole; mole_sel = HW'($urandom);
            step("sat_hit");
            hit_btn = '0;
            step("sat_rel");
        end
        run_idle(4, "game_b_end");

        // Reset in the middle of a round.
        mole_sel = 2'd3; start = 1'b1;
        step("start_c");
        start = 1'b0;
        run_idle(5, "pre_rst");
        Reset = 1'b1; step("rst_mid");
        Reset = 1'b0; run_idle(5, "post_rst");

        // Randomized games; address wraps after four writes.
        for (int g = 0; g < 6; g++) begin
            mole_sel = HW'($urandom); start = 1'b1;
            step("start_rand");
            start = 1'b0;
            for (int c = 0; c < 200 && md != 4; c++) begin
                if ($urandom_range(0, 2) == 0) hit_btn = NH'($urandom);
                mole_sel = HW'($urandom);
                start    = ($urandom_range(0, 7) == 0) && (md != 3);
                step("rand");
            end
            start = 1'b0; hit_btn = '0;
            if (md != 4) begin
                compared++; mismatched++;
                $error("FAIL rand_game_bound got md=%0d required 4", md);
            end
            run_idle(2, "rand_done");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
